// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and line levels used by the
// transmit framer and the future receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses tick on the last
// count. clear restarts the period so bit boundaries align to frame start.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] baud_cnt_q;
    logic [CW-1:0] baud_cnt_d;

    // Next count: restart on clear or wrap, otherwise advance.
    always_comb begin
        tick       = (baud_cnt_q == LAST);
        baud_cnt_d = baud_cnt_q + CW'(1);
        if (clear || tick) begin
            baud_cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baud_cnt_q <= '0;
        end else begin
            baud_cnt_q <= baud_cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: one-byte holding register behind a valid/ready
// handshake, shift register and bit counter driving a registered tx line.
// Frames are start(0), DATA_WIDTH bits LSB first, STOP_BITS stop(1).
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  valid,
    output logic                  ready,
    output logic                  tx,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

    uart_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
    logic                  hold_full_q, hold_full_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  tx_q, tx_d;
    logic                  accept;
    logic                  baud_clear;
    logic                  baud_tick;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .reset(reset),
        .clear(baud_clear),
        .tick (baud_tick)
    );

    assign ready  = !hold_full_q;
    assign accept = valid && ready;
    assign tx     = tx_q;
    assign busy   = (state_q != IDLE) || hold_full_q;

    // Next-state, holding register, shifter and line level.
    always_comb begin
        state_d     = state_q;
        hold_data_d = hold_data_q;
        hold_full_d = hold_full_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        baud_clear  = 1'b0;

        if (accept) begin
            hold_data_d = data;
            hold_full_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    shreg_d     = hold_data_q;
                    hold_full_d = 1'b0;
                    bit_cnt_d   = '0;
                    baud_clear  = 1'b1;
                    state_d     = START;
                end
            end
            START: begin
                if (baud_tick) begin
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
                        state_d   = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        bit_cnt_d = '0;
                        if (hold_full_q) begin
                            shreg_d     = hold_data_q;
                            hold_full_d = 1'b0;
                            baud_clear  = 1'b1;
                            state_d     = START;
                        end else if (accept) begin
                            // Byte arriving on the last stop edge goes
                            // straight to the shifter; nothing is held.
                            shreg_d     = data;
                            hold_full_d = 1'b0;
                            baud_clear  = 1'b1;
                            state_d     = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // tx is registered, so it is derived from the state being entered.
        unique case (state_d)
            START:   tx_d = START_LEVEL;
            DATA:    tx_d = shreg_d[0];
            default: tx_d = IDLE_LEVEL;
        endcase
    end

    // State and datapath registers; reset returns the line to idle at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            hold_data_q <= '0;
            hold_full_q <= 1'b0;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            tx_q        <= IDLE_LEVEL;
        end else begin
            state_q     <= state_d;
            hold_data_q <= hold_data_d;
            hold_full_q <= hold_full_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_q        <= tx_d;
        end
    end

endmodule
